// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and payload types for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned REG_W   = 5;

    localparam logic [REG_W-1:0] REG_X0 = '0;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    // Per-cycle pipeline register control bundle.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_hold;
    } ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (inc && (q_q != {W{1'b1}})) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: hazard priority logic,
// data-memory wait timeout FSM and saturating stall/flush counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [REG_W-1:0]   id_rs1_i,
    input  logic [REG_W-1:0]   id_rs2_i,
    input  logic               id_use_rs1_i,
    input  logic               id_use_rs2_i,
    input  logic               ex_memread_i,
    input  logic [REG_W-1:0]   ex_rd_i,
    input  logic               branch_taken_i,
    input  logic               dmem_req_i,
    input  logic               dmem_ready_i,
    output logic               pc_write_o,
    output logic               ifid_write_o,
    output logic               ifid_flush_o,
    output logic               idex_bubble_o,
    output logic               pipe_hold_o,
    output logic [STATE_W-1:0] state_o,
    output logic               error_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
);

    localparam int unsigned WAIT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    state_e            state_q;
    state_e            state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;

    logic  mem_stall;
    logic  rs1_hit;
    logic  rs2_hit;
    logic  load_use;
    logic  timeout_hit;
    ctrl_t ctrl;

    assign mem_stall   = dmem_req_i & ~dmem_ready_i;
    assign rs1_hit     = id_use_rs1_i & (id_rs1_i == ex_rd_i);
    assign rs2_hit     = id_use_rs2_i & (id_rs2_i == ex_rd_i);
    assign load_use    = ex_memread_i & (ex_rd_i != REG_X0) & (rs1_hit | rs2_hit);
    assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // wait_q counts consecutive stalled cycles; ERROR is only left via reset.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else if (timeout_hit) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Priority: error > memory stall > load-use > taken branch > normal flow.
    always_comb begin
        ctrl = '0;
        if (rst_i) begin
            ctrl = '0;
        end else if (state_q == ST_ERROR) begin
            ctrl.pipe_hold = 1'b1;
        end else if (mem_stall) begin
            ctrl.pipe_hold = 1'b1;
        end else if (load_use) begin
            ctrl.idex_bubble = 1'b1;
        end else begin
            ctrl.pc_write   = 1'b1;
            ctrl.ifid_write = 1'b1;
            ctrl.ifid_flush = branch_taken_i;
        end
    end

    assign pc_write_o    = ctrl.pc_write;
    assign ifid_write_o  = ctrl.ifid_write;
    assign ifid_flush_o  = ctrl.ifid_flush;
    assign idex_bubble_o = ctrl.idex_bubble;
    assign pipe_hold_o   = ctrl.pipe_hold;
    assign state_o       = state_q;
    assign error_o       = (state_q == ST_ERROR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk_i),
        .rst (rst_i),
        .inc (~rst_i & ~ctrl.pc_write),
        .q   (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk_i),
        .rst (rst_i),
        .inc (ctrl.ifid_flush),
        .q   (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench: two controller instances (default and small CNT_W/TIMEOUT) against a
// behavioural model, plus directed literal checks.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, br, req, rdy;

    logic        pc_a, ifw_a, fl_a, bub_a, hold_a, err_a;
    logic [1:0]  st_a;
    logic [15:0] scnt_a, fcnt_a;
    logic        pc_b, ifw_b, fl_b, bub_b, hold_b, err_b;
    logic [1:0]  st_b;
    logic [2:0]  scnt_b, fcnt_b;

    pipeline_hazard_ctrl #(.CNT_W(16), .TIMEOUT(64)) dut_a (
        .clk_i(clk), .rst_i(rst), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_use_rs1_i(u1), .id_use_rs2_i(u2), .ex_memread_i(mr), .ex_rd_i(rd),
        .branch_taken_i(br), .dmem_req_i(req), .dmem_ready_i(rdy),
        .pc_write_o(pc_a), .ifid_write_o(ifw_a), .ifid_flush_o(fl_a),
        .idex_bubble_o(bub_a), .pipe_hold_o(hold_a), .state_o(st_a),
        .error_o(err_a), .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a)
    );

    pipeline_hazard_ctrl #(.CNT_W(3), .TIMEOUT(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_use_rs1_i(u1), .id_use_rs2_i(u2), .ex_memread_i(mr), .ex_rd_i(rd),
        .branch_taken_i(br), .dmem_req_i(req), .dmem_ready_i(rdy),
        .pc_write_o(pc_b), .ifid_write_o(ifw_b), .ifid_flush_o(fl_b),
        .idex_bubble_o(bub_b), .pipe_hold_o(hold_b), .state_o(st_b),
        .error_o(err_b), .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b)
    );

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model state: sticky error, length of the current memory-stall run, counters.
    int m_err[2], m_run[2], m_stall[2], m_flush[2];

    typedef struct packed {
        logic pc, ifw, flush, bubble, hold;
    } exp_t;

    function automatic int tmo(int k);
        return (k == 0) ? 64 : 4;
    endfunction

    function automatic int cmax(int k);
        return (k == 0) ? 65535 : 7;
    endfunction

    function automatic bit ms_now();
        return req && !rdy;
    endfunction

    function automatic exp_t model_ctrl(int k);
        exp_t e;
        bit   lu;
        e  = '0;
        lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (rst) return e;
        if (m_err[k] != 0 || ms_now()) e.hold = 1'b1;
        else if (lu) e.bubble = 1'b1;
        else begin
            e.pc    = 1'b1;
            e.ifw   = 1'b1;
            e.flush = br;
        end
        return e;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 0; m_run[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            e = model_ctrl(k);
            if (rst) begin
                m_err[k] = 0; m_run[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
            end else begin
                if (!e.pc && m_stall[k] < cmax(k)) m_stall[k]++;
                if (e.flush && m_flush[k] < cmax(k)) m_flush[k]++;
                if (m_err[k] == 0) begin
                    if (ms_now()) begin
                        if (tmo(k) != 0 && m_run[k] >= tmo(k)) m_err[k] = 1;
                        else m_run[k]++;
                    end else begin
                        m_run[k] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                exp_t e;
                int   est;
                e   = model_ctrl(k);
                est = (m_err[k] != 0) ? 2 : ((m_run[k] > 0) ? 1 : 0);
                chk($sformatf("dut%0d pc_write", k),    int'(k == 0 ? pc_a : pc_b),     int'(e.pc));
                chk($sformatf("dut%0d ifid_write", k),  int'(k == 0 ? ifw_a : ifw_b),   int'(e.ifw));
                chk($sformatf("dut%0d ifid_flush", k),  int'(k == 0 ? fl_a : fl_b),     int'(e.flush));
                chk($sformatf("dut%0d idex_bubble", k), int'(k == 0 ? bub_a : bub_b),   int'(e.bubble));
                chk($sformatf("dut%0d pipe_hold", k),   int'(k == 0 ? hold_a : hold_b), int'(e.hold));
                chk($sformatf("dut%0d state", k),       int'(k == 0 ? st_a : st_b),     est);
                chk($sformatf("dut%0d error", k),       int'(k == 0 ? err_a : err_b),   int'(m_err[k] != 0));
                chk($sformatf("dut%0d stall_cnt", k),   (k == 0) ? int'(scnt_a) : int'(scnt_b), m_stall[k]);
                chk($sformatf("dut%0d flush_cnt", k),   (k == 0) ? int'(fcnt_a) : int'(fcnt_b), m_flush[k]);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] i_rs1, input logic [4:0] i_rs2,
                         input logic i_u1, input logic i_u2, input logic i_mr,
                         input logic [4:0] i_rd, input logic i_br,
                         input logic i_req, input logic i_rdy);
        next_cycle();
        rst = 1'b0;
        rs1 = i_rs1; rs2 = i_rs2; u1 = i_u1; u2 = i_u2;
        mr = i_mr; rd = i_rd; br = i_br; req = i_req; rdy = i_rdy;
        @(negedge clk);
    endtask

    task automatic set_idle();
        rs1 = '0; rs2 = '0; u1 = 1'b0; u2 = 1'b0;
        mr = 1'b0; rd = '0; br = 1'b0; req = 1'b0; rdy = 1'b0;
    endtask

    task automatic do_reset(input int n);
        next_cycle();
        rst = 1'b1;
        set_idle();
        repeat (n - 1) next_cycle();
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mstall();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int burst;
        rst = 1'b1;
        set_idle();
        do_reset(3);
        chk_en = 1'b1;

        idle();
        chk("rst_pc", int'(pc_a), 1);
        chk("rst_ifw", int'(ifw_a), 1);
        chk("rst_hold", int'(hold_a), 0);
        chk("rst_state", int'(st_a), 0);
        chk("rst_scnt", int'(scnt_a), 0);
        chk("rst_fcnt", int'(fcnt_a), 0);

        drive(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("lu_pc", int'(pc_a), 0);
        chk("lu_ifw", int'(ifw_a), 0);
        chk("lu_bubble", int'(bub_a), 1);
        idle();
        chk("lu_scnt", int'(scnt_a), 1);
        drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("x0_pc", int'(pc_a), 1);
        chk("x0_bubble", int'(bub_a), 0);

        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("br_flush", int'(fl_a), 1);
        idle();
        chk("br_fcnt", int'(fcnt_a), 1);
        drive(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("brlu_bubble", int'(bub_a), 1);
        chk("brlu_flush", int'(fl_a), 0);
        idle();
        chk("brlu_fcnt", int'(fcnt_a), 1);
        chk("brlu_scnt", int'(scnt_a), 2);

        for (int i = 1; i <= 4; i++) begin
            mstall();
            chk("ms_hold", int'(hold_a), 1);
            chk("ms_state", int'(st_a), (i == 1) ? 0 : 1);
        end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("rel_state", int'(st_a), 1);
        chk("rel_pc", int'(pc_a), 1);
        chk("rel_hold", int'(hold_a), 0);
        idle();
        chk("post_state", int'(st_a), 0);
        chk("post_scnt", int'(scnt_a), 6);

        do_reset(1);
        for (int i = 1; i <= 5; i++) begin
            mstall();
            chk("to_pre_err", int'(err_b), 0);
        end
        mstall();
        chk("to_state", int'(st_b), 2);
        chk("to_err", int'(err_b), 1);
        chk("to_hold", int'(hold_b), 1);
        chk("to_a_state", int'(st_a), 1);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("to_sticky", int'(err_b), 1);
        chk("to_sticky_hold", int'(hold_b), 1);
        chk("to_a_pc", int'(pc_a), 1);
        do_reset(1);
        idle();
        chk("to_clr_err", int'(err_b), 0);
        chk("to_clr_pc", int'(pc_b), 1);

        do_reset(1);
        repeat (10) drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        idle();
        chk("sat_b", int'(scnt_b), 7);
        chk("sat_a", int'(scnt_a), 10);

        do_reset(1);
        for (int i = 1; i <= 66; i++) begin
            mstall();
            if (i == 65) chk("to64_pre", int'(st_a), 1);
            if (i == 66) chk("to64_err", int'(err_a), 1);
        end

        do_reset(2);
        burst = 0;
        repeat (3000) begin
            next_cycle();
            rst = ($urandom_range(0, 199) == 0);
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            u1  = 1'($urandom);
            u2  = 1'($urandom);
            mr  = ($urandom_range(0, 2) == 0);
            br  = ($urandom_range(0, 3) == 0);
            if (burst > 0) begin
                burst--;
                req = 1'b1;
                rdy = 1'b0;
            end else begin
                if ($urandom_range(0, 99) == 0) burst = $urandom_range(3, 70);
                req = ($urandom_range(0, 2) == 0);
                rdy = 1'($urandom);
            end
        end
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB registers and decides, every cycle, whether each one advances, holds, takes a bubble or is squashed. Its inputs are ID-stage operand usage, the EX-stage load destination, ID-stage branch resolution and a data-memory ready handshake. It also maintains a memory-wait timeout FSM and saturating performance counters.

Parameters:
CNT_W, 16, width of stall and flush performance counters
TIMEOUT, 64, max consecutive data-memory wait cycles before the error state; 0 disables the timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
id_rs1_i  in  5  rs1 field of the instruction in ID
id_rs2_i  in  5  rs2 field of the instruction in ID
id_use_rs1_i  in  1  ID instruction reads rs1
id_use_rs2_i  in  1  ID instruction reads rs2
ex_memread_i  in  1  MemRead of the ID/EX register contents
ex_rd_i  in  5  rd of the ID/EX register contents
branch_taken_i  in  1  branch resolved taken in ID this cycle
dmem_req_i  in  1  MEM stage is accessing data memory (MemRead or MemWrite)
dmem_ready_i  in  1  data memory completes the access this cycle
pc_write_o  out  1  PC may update
ifid_write_o  out  1  IF/ID register may load
ifid_flush_o  out  1  IF/ID loads zeros (squash)
idex_bubble_o  out  1  ID/EX loads zero control signals
pipe_hold_o  out  1  ID/EX, EX/MEM and MEM/WB hold their contents
state_o  out  2  FSM state (RUN=0, MEM_WAIT=1, ERROR=2)
error_o  out  1  sticky timeout error
stall_cnt_o  out  CNT_W  cycles with pc_write_o=0, saturating
flush_cnt_o  out  CNT_W  cycles with ifid_flush_o=1, saturating

Behaviour:
- Reset (rst_i=1 at a clock edge): state=RUN, wait_cnt=0, error_o=0, both counters=0. While rst_i=1, all control outputs are forced: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0, pipe_hold_o=0. Counters do not count during reset.
- Outputs are combinational from the current state and inputs. State and counters update on the rising edge.
- mem_stall = dmem_req_i & ~dmem_ready_i.
- load_use = ex_memread_i & (ex_rd_i≠0) & ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i)).
- Priority: ERROR > mem_stall > load_use > branch_taken_i.
- ERROR: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, idex_bubble_o=0, ifid_flush_o=0, error_o=1. ERROR is left only by reset.
- mem_stall, in RUN or MEM_WAIT: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, idex_bubble_o=0, ifid_flush_o=0. The whole pipe freezes, and a concurrent load-use or branch is re-evaluated after release.
- load_use with no mem_stall: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, pipe_hold_o=0, ifid_flush_o=0. This lasts exactly 1 cycle, because the load advances to MEM. A same-cycle branch_taken_i is ignored and re-presented next cycle.
- branch_taken_i alone: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, and all other hold/bubble outputs are 0.
- Otherwise: pc_write_o=1, ifid_write_o=1, and all other outputs are 0.
- FSM transitions:
  - RUN→MEM_WAIT when mem_stall; wait_cnt←1.
  - MEM_WAIT stays while mem_stall; wait_cnt increments.
  - MEM_WAIT→RUN when ~mem_stall; wait_cnt←0. The release cycle already has normal outputs.
  - MEM_WAIT→ERROR when mem_stall & TIMEOUT≠0 & wait_cnt==TIMEOUT.
- Counters:
  - stall_cnt increments on every non-reset cycle with pc_write_o=0, including ERROR.
  - flush_cnt increments when ifid_flush_o=1.
  - Both hold at 2^CNT_W−1.
- rd=x0 never causes a load-use stall.
- wait_cnt is ceil(log2(TIMEOUT+1)) bits wide, with a minimum of 1.

Decomposition:
- Shared package pipe_ctrl_pkg holds the state encodings (RUN/MEM_WAIT/ERROR), the state width and the x0 register index constant.
- One natural sub-module is sat_counter (parameter W; ports clk, rst, inc, q), instantiated twice for the stall and flush counters.

Test Plan:
1. Reset held 3 cycles, then released with idle inputs → all holds 0, pc_write_o=ifid_write_o=1, state_o=0, counters=0.
2. ex_memread_i=1, ex_rd_i=5, id_rs2_i=5, id_use_rs2_i=1 for 1 cycle → that cycle pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; stall_cnt=1. Repeat with ex_rd_i=0 → no stall.
3. branch_taken_i=1 alone → ifid_flush_o=1, flush_cnt increments by 1. Then branch_taken_i=1 together with load_use → bubble only, flush_cnt unchanged.
4. dmem_req_i=1, dmem_ready_i=0 for 4 cycles, then ready=1 → pipe_hold_o=1 for 4 cycles; state_o=1 from cycle 2 through cycle 5; release cycle has normal outputs; state_o=0 after; stall_cnt=+4.
5. TIMEOUT=4, dmem_ready_i held 0 → ERROR entered after 5 stalled cycles; error_o=1 and holds stay asserted until rst_i=1.
6. CNT_W=3 with 10 consecutive load-use cycles → stall_cnt_o saturates at 7.
